// File: rtl/l3_access_ctrl.sv
// Round-robin sequencer that shares one write-through L3 between the I-side and D-side L2s.
// Read misses fetch from memory and fill the L3; every write goes to memory.
module l3_access_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                req_valid_i,
   input  logic [1:0]                req_wr_en_i,
   input  logic [2*ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [2*DATA_WIDTH-1:0]   req_wr_data_i,
   input  logic [2*DATA_WIDTH/8-1:0] req_byte_en_i,
   output logic [1:0]                req_done_o,
   output logic [DATA_WIDTH-1:0]     rd_data_o,
   output logic                      l3_wr_en_o,
   output logic [ADDR_WIDTH-1:0]     l3_addr_o,
   output logic [DATA_WIDTH-1:0]     l3_wr_data_o,
   output logic [DATA_WIDTH/8-1:0]   l3_byte_en_o,
   output logic                      l3_mem_valid_o,
   output logic [DATA_WIDTH-1:0]     l3_mem_data_o,
   input  logic [DATA_WIDTH-1:0]     l3_rd_data_i,
   input  logic                      l3_hit_i,
   output logic                      mem_req_o,
   output logic                      mem_we_o,
   output logic [ADDR_WIDTH-1:0]     mem_addr_o,
   output logic [DATA_WIDTH-1:0]     mem_wr_data_o,
   output logic [DATA_WIDTH/8-1:0]   mem_byte_en_o,
   input  logic                      mem_ack_i,
   input  logic [DATA_WIDTH-1:0]     mem_rd_data_i,
   output logic [CNT_WIDTH-1:0]      hit_cnt_o,
   output logic [CNT_WIDTH-1:0]      miss_cnt_o
);
   localparam int BE_W = DATA_WIDTH / 8;

   typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, RESP} state_t;

   state_t                state, state_nx;
   logic                  rr_ptr;
   logic                  gnt;
   logic                  gnt_sel;
   logic                  op_we;
   logic [ADDR_WIDTH-1:0] op_addr;
   logic [DATA_WIDTH-1:0] op_wdata;
   logic [BE_W-1:0]       op_be;
   logic [DATA_WIDTH-1:0] data_q;
   logic [CNT_WIDTH-1:0]  hit_cnt, miss_cnt;

   // Contention goes to rr_ptr; a lone requester is granted directly.
   assign gnt_sel = (&req_valid_i) ? rr_ptr : req_valid_i[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= 1'b0;
         gnt      <= 1'b0;
         op_we    <= 1'b0;
         op_addr  <= '0;
         op_wdata <= '0;
         op_be    <= '0;
         data_q   <= '0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid_i) begin
                  gnt      <= gnt_sel;
                  rr_ptr   <= ~gnt_sel;
                  op_we    <= req_wr_en_i[gnt_sel];
                  op_addr  <= gnt_sel ? req_addr_i[ADDR_WIDTH +: ADDR_WIDTH]
                                      : req_addr_i[0 +: ADDR_WIDTH];
                  op_wdata <= gnt_sel ? req_wr_data_i[DATA_WIDTH +: DATA_WIDTH]
                                      : req_wr_data_i[0 +: DATA_WIDTH];
                  op_be    <= gnt_sel ? req_byte_en_i[BE_W +: BE_W]
                                      : req_byte_en_i[0 +: BE_W];
               end
            end
            LOOKUP: begin
               if (l3_hit_i) begin
                  if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_WIDTH'(1);
               end else begin
                  if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
               end
               // Writes return zero data; read hits return the L3 word.
               if (op_we) data_q <= '0;
               else if (l3_hit_i) data_q <= l3_rd_data_i;
            end
            MEM_RD: begin
               if (mem_ack_i) data_q <= mem_rd_data_i;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx       = state;
      req_done_o     = '0;
      rd_data_o      = '0;
      l3_wr_en_o     = 1'b0;
      l3_addr_o      = '0;
      l3_wr_data_o   = '0;
      l3_byte_en_o   = '0;
      l3_mem_valid_o = 1'b0;
      l3_mem_data_o  = '0;
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_o     = '0;
      mem_wr_data_o  = '0;
      mem_byte_en_o  = '0;
      case (state)
         IDLE: begin
            if (|req_valid_i) state_nx = LOOKUP;
         end
         LOOKUP: begin
            l3_addr_o    = op_addr;
            l3_wr_en_o   = op_we;
            l3_wr_data_o = op_wdata;
            l3_byte_en_o = op_be;
            if (op_we)         state_nx = MEM_WR;
            else if (l3_hit_i) state_nx = RESP;
            else               state_nx = MEM_RD;
         end
         MEM_RD: begin
            mem_req_o  = 1'b1;
            mem_addr_o = op_addr;
            if (mem_ack_i) state_nx = FILL;
         end
         FILL: begin
            l3_addr_o      = op_addr;
            l3_mem_valid_o = 1'b1;
            l3_mem_data_o  = data_q;
            state_nx       = RESP;
         end
         MEM_WR: begin
            mem_req_o     = 1'b1;
            mem_we_o      = 1'b1;
            mem_addr_o    = op_addr;
            mem_wr_data_o = op_wdata;
            mem_byte_en_o = op_be;
            if (mem_ack_i) state_nx = RESP;
         end
         RESP: begin
            req_done_o[gnt] = 1'b1;
            rd_data_o       = data_q;
            state_nx        = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign hit_cnt_o  = hit_cnt;
   assign miss_cnt_o = miss_cnt;

endmodule

// File: tb/tb_l3_access_ctrl.sv
// Scoreboard bench: drivers push expected responses from an address-level reference model;
// a negedge monitor pops them on every done pulse. L3 and memory are behavioural environment models.
module tb_l3_access_ctrl;
   localparam int AW = 32, DW = 32, CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic          a_valid[2], a_we[2];
   logic [31:0]   a_addr[2], a_wdata[2];
   logic [3:0]    a_be[2];
   logic [1:0]    req_valid_i, req_wr_en_i, req_done_o;
   logic [63:0]   req_addr_i, req_wr_data_i;
   logic [7:0]    req_byte_en_i;
   logic [31:0]   rd_data_o, l3_addr_o, l3_wr_data_o, l3_mem_data_o, l3_rd_data_i;
   logic [31:0]   mem_addr_o, mem_wr_data_o, mem_rd_data_i;
   logic [3:0]    l3_byte_en_o, mem_byte_en_o;
   logic          l3_wr_en_o, l3_mem_valid_o, l3_hit_i, mem_req_o, mem_we_o, mem_ack_i;
   logic [CW-1:0] hit_cnt_o, miss_cnt_o;

   assign req_valid_i   = {a_valid[1], a_valid[0]};
   assign req_wr_en_i   = {a_we[1], a_we[0]};
   assign req_addr_i    = {a_addr[1], a_addr[0]};
   assign req_wr_data_i = {a_wdata[1], a_wdata[0]};
   assign req_byte_en_i = {a_be[1], a_be[0]};

   l3_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_wr_en_i(req_wr_en_i), .req_addr_i(req_addr_i),
      .req_wr_data_i(req_wr_data_i), .req_byte_en_i(req_byte_en_i),
      .req_done_o(req_done_o), .rd_data_o(rd_data_o),
      .l3_wr_en_o(l3_wr_en_o), .l3_addr_o(l3_addr_o), .l3_wr_data_o(l3_wr_data_o),
      .l3_byte_en_o(l3_byte_en_o), .l3_mem_valid_o(l3_mem_valid_o), .l3_mem_data_o(l3_mem_data_o),
      .l3_rd_data_i(l3_rd_data_i), .l3_hit_i(l3_hit_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wr_data_o(mem_wr_data_o), .mem_byte_en_o(mem_byte_en_o),
      .mem_ack_i(mem_ack_i), .mem_rd_data_i(mem_rd_data_i),
      .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   int vectors = 0, miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a * 32'h9E3779B9) ^ 32'h5A5A5A5A;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   // Environment: L3 contents and main memory, driven purely by DUT port activity.
   logic [31:0] env_cache[logic [31:0]];
   logic [31:0] env_mem[logic [31:0]];
   int  mem_wait = 0, mem_lat = 0;
   bit  rand_lat = 0;
   int  fill_cnt = 0, memwr_cnt = 0, memreq_cyc = 0, l3wr_cnt = 0;
   logic [31:0] last_fill_addr, last_fill_data, last_mw_addr, last_mw_data;
   logic [3:0]  last_mw_be;

   // Reference model: address-level view of memory, cached lines and hit/miss totals.
   logic [31:0] ref_mem[logic [31:0]];
   bit          ref_cached[logic [31:0]];
   int          ref_hits = 0, ref_miss = 0;
   logic [31:0] exp_q0[$], exp_q1[$];
   int          done_log[$];

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   int mk;
   logic [31:0] me;
   always @(negedge clk) begin
      l3_hit_i     = env_cache.exists(l3_addr_o);
      l3_rd_data_i = l3_hit_i ? env_cache[l3_addr_o] : 32'hBAD0BAD0;
      if (!mem_req_o) begin
         mem_wait = 0; mem_ack_i = 1'b0; mem_rd_data_i = '0;
         if (rand_lat) mem_lat = $urandom_range(0, 3);
      end else begin
         memreq_cyc++;
         if (mem_wait >= mem_lat) begin
            mem_ack_i     = 1'b1;
            mem_rd_data_i = env_mem.exists(mem_addr_o) ? env_mem[mem_addr_o] : init_val(mem_addr_o);
            mem_wait      = 0;
         end else begin
            mem_ack_i = 1'b0; mem_rd_data_i = '0; mem_wait++;
         end
      end
      if (!rst) begin
         if (l3_wr_en_o) begin
            l3wr_cnt++;
            if (l3_hit_i) env_cache[l3_addr_o] = merge(env_cache[l3_addr_o], l3_wr_data_o, l3_byte_en_o);
         end
         if (l3_mem_valid_o) begin
            env_cache[l3_addr_o] = l3_mem_data_o;
            fill_cnt++; last_fill_addr = l3_addr_o; last_fill_data = l3_mem_data_o;
         end
         if (mem_req_o && mem_ack_i && mem_we_o) begin
            env_mem[mem_addr_o] = merge(env_mem.exists(mem_addr_o) ? env_mem[mem_addr_o] : init_val(mem_addr_o),
                                        mem_wr_data_o, mem_byte_en_o);
            memwr_cnt++; last_mw_addr = mem_addr_o; last_mw_data = mem_wr_data_o; last_mw_be = mem_byte_en_o;
         end
      end
      if (req_done_o != 2'b00) begin
         chk("done_onehot", 64'($onehot(req_done_o)), 64'd1);
         mk = req_done_o[1] ? 1 : 0;
         if ((mk == 0 && exp_q0.size() == 0) || (mk == 1 && exp_q1.size() == 0)) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_done: got done=%b expected none (cycle %0d)", req_done_o, cyc);
         end else begin
            me = (mk == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk(mk == 0 ? "rd_data_req0" : "rd_data_req1", 64'(rd_data_o), 64'(me));
            done_log.push_back(mk);
         end
      end
   end

   // Issue one op from requester k (called at posedge+1) and wait for its done pulse.
   task automatic do_op(input int k, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output int lat);
      logic [31:0] e;
      int c0, n;
      if (ref_cached.exists(addr)) ref_hits++; else ref_miss++;
      if (we) begin
         ref_mem[addr] = merge(ref_rd(addr), wdata, be);
         e = '0;
      end else begin
         e = ref_rd(addr);
         ref_cached[addr] = 1'b1;
      end
      if (k == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      a_valid[k] = 1'b1; a_we[k] = we; a_addr[k] = addr; a_wdata[k] = wdata; a_be[k] = be;
      c0 = cyc; n = 0;
      @(negedge clk);
      while (!req_done_o[k] && n < 300) begin @(negedge clk); n++; end
      if (!req_done_o[k]) begin
         vectors++; miscompares++;
         $display("FAIL done_timeout: got no done for req%0d expected done within 300 cycles", k);
      end
      lat = cyc - c0;
      @(posedge clk); #1;
      a_valid[k] = 1'b0;
   endtask

   task automatic rand_driver(input int k, input int nops);
      int lat;
      logic [31:0] base;
      base = (k == 0) ? 32'h1000 : 32'h2000;
      for (int i = 0; i < nops; i++) begin
         do_op(k, bit'($urandom_range(0, 1)), base + 4 * $urandom_range(0, 7), $urandom,
               4'($urandom_range(0, 15)), lat);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic check_cnts(input string tag);
      chk({tag, "_hit_cnt"}, 64'(hit_cnt_o), 64'(sat(ref_hits)));
      chk({tag, "_miss_cnt"}, 64'(miss_cnt_o), 64'(sat(ref_miss)));
   endtask

   function automatic logic any_out();
      return |{req_done_o, rd_data_o, l3_wr_en_o, l3_addr_o, l3_wr_data_o, l3_byte_en_o, l3_mem_valid_o,
               l3_mem_data_o, mem_req_o, mem_we_o, mem_addr_o, mem_wr_data_o, mem_byte_en_o, hit_cnt_o, miss_cnt_o};
   endfunction

   int lat, f0, w0, r0, l0, idx0, n;
   initial begin
      for (int k = 0; k < 2; k++) begin
         a_valid[k] = 0; a_we[k] = 0; a_addr[k] = 0; a_wdata[k] = 0; a_be[k] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs_zero", 64'(any_out()), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_reset_outputs_zero", 64'(any_out()), 64'd0);
      @(posedge clk); #1;

      // Read miss, memory answers after 2 wait cycles.
      env_mem[32'h100] = 32'hDEADBEEF; ref_mem[32'h100] = 32'hDEADBEEF;
      mem_lat = 2; f0 = fill_cnt;
      do_op(0, 0, 32'h100, 0, 4'hF, lat);
      chk("miss_fill_count", 64'(fill_cnt - f0), 64'd1);
      chk("miss_fill_addr", 64'(last_fill_addr), 64'h100);
      chk("miss_fill_data", 64'(last_fill_data), 64'hDEADBEEF);
      chk("miss_latency", 64'(lat), 64'd6);
      chk("miss_cnt_1", 64'(miss_cnt_o), 64'd1);

      // Read hit on the filled line.
      r0 = memreq_cyc;
      do_op(0, 0, 32'h100, 0, 4'hF, lat);
      chk("hit_no_memreq", 64'(memreq_cyc - r0), 64'd0);
      chk("hit_latency", 64'(lat), 64'd2);
      chk("hit_cnt_1", 64'(hit_cnt_o), 64'd1);

      // Contention: both requesters continuously valid must alternate.
      idx0 = done_log.size();
      fork
         begin for (int i = 0; i < 4; i++) do_op(0, 0, 32'h100, 0, 4'hF, lat); end
         begin for (int i = 0; i < 4; i++) do_op(1, 0, 32'h100, 0, 4'hF, lat); end
      join
      chk("rr_ops", 64'(done_log.size() - idx0), 64'd8);
      for (int i = idx0 + 1; i < done_log.size(); i++)
         chk("rr_alternate", 64'(done_log[i] != done_log[i-1]), 64'd1);

      // Write hit from requester 1, partial byte enables.
      mem_lat = 1; w0 = memwr_cnt; l0 = l3wr_cnt; f0 = fill_cnt;
      do_op(1, 1, 32'h100, 32'h11223344, 4'b0011, lat);
      chk("wr_hit_l3_wr_en", 64'(l3wr_cnt - l0), 64'd1);
      chk("wr_hit_mem_count", 64'(memwr_cnt - w0), 64'd1);
      chk("wr_hit_mem_be", 64'(last_mw_be), 64'b0011);
      chk("wr_hit_mem_data", 64'(last_mw_data), 64'h11223344);
      chk("wr_hit_mem_addr", 64'(last_mw_addr), 64'h100);
      do_op(0, 0, 32'h100, 0, 4'hF, lat);
      chk("wr_hit_merged_line", 64'(env_cache[32'h100]), 64'hDEAD3344);

      // Write miss: memory updated, no allocate.
      w0 = memwr_cnt;
      do_op(0, 1, 32'h200, 32'hCAFEF00D, 4'b1111, lat);
      chk("wr_miss_no_fill", 64'(fill_cnt - f0), 64'd0);
      chk("wr_miss_mem_count", 64'(memwr_cnt - w0), 64'd1);
      chk("wr_miss_no_alloc", 64'(env_cache.exists(32'h200)), 64'd0);
      check_cnts("directed");

      // Reset during MEM_RD drops the op silently.
      mem_lat = 50;
      a_valid[0] = 1; a_we[0] = 0; a_addr[0] = 32'h300;
      n = 0;
      @(negedge clk);
      while (!mem_req_o && n < 20) begin @(negedge clk); n++; end
      chk("reached_mem_rd", 64'(mem_req_o), 64'd1);
      rst = 1'b1; a_valid[0] = 0;
      @(negedge clk);
      chk("midop_reset_outputs_zero", 64'(any_out()), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      ref_hits = 0; ref_miss = 0; mem_lat = 0;
      repeat (4) @(posedge clk); #1;
      check_cnts("after_reset");

      // Saturation of the hit counter.
      for (int i = 0; i < CMAX - 1; i++) do_op(0, 0, 32'h100, 0, 4'hF, lat);
      chk("hit_cnt_max_minus_1", 64'(hit_cnt_o), 64'(CMAX - 1));
      do_op(1, 0, 32'h100, 0, 4'hF, lat);
      do_op(0, 0, 32'h100, 0, 4'hF, lat);
      chk("hit_cnt_saturated", 64'(hit_cnt_o), 64'(CMAX));

      // Randomized concurrent traffic in disjoint address regions.
      rand_lat = 1;
      fork
         rand_driver(0, 30);
         rand_driver(1, 30);
      join
      repeat (3) @(posedge clk); #1;
      check_cnts("random");
      chk("queues_drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish before 2000000");
      $fatal(1, "timeout");
   end

endmodule
